id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU. It captures decoded instruction fields each cycle and supports stall (hold) and flush (bubble insertion). It resolves RAW hazards by forwarding EX/MEM and MEM/WB results, then presents `ALUCtrl`, `ALUop1` and `ALUop2` to the ALU together with the execute-stage side-band fields.

## Interface
- `DATA_WIDTH`, 32, operand/PC/immediate width
- `ALUCTRL_WIDTH`, 4, ALU opcode width ({func7[5], func3})
- `REG_ADDR_WIDTH`, 5, register index width
- `clk` in 1: rising-edge clock; the block's only clock
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: hold all ID/EX registers
- `flush` in 1: load a bubble on the next edge
- `valid_d` in 1: decode slot holds a real instruction
- `pc_d`, `rs1_data_d`, `rs2_data_d`, `imm_d` in DATA_WIDTH: decoded values
- `rs1_addr_d`, `rs2_addr_d`, `rd_addr_d` in REG_ADDR_WIDTH: register indices
- `alu_ctrl_d` in ALUCTRL_WIDTH: ALU opcode
- `alu_src_a_d` in 1: 1 selects PC as operand 1 (AUIPC/JAL)
- `alu_src_b_d` in 1: 1 selects the immediate as operand 2
- `reg_write_d`, `mem_write_d`, `mem_to_reg_d` in 1: control side-band
- `exm_rd`, `mwb_rd` in REG_ADDR_WIDTH: destinations of the downstream stages
- `exm_reg_write`, `mwb_reg_write` in 1: downstream write enables
- `exm_result`, `mwb_result` in DATA_WIDTH: downstream result values
- `ALUCtrl` out ALUCTRL_WIDTH: to ALU
- `ALUop1`, `ALUop2` out DATA_WIDTH: to ALU
- `store_data_e` out DATA_WIDTH: forwarded rs2 value, for stores
- `pc_e` out DATA_WIDTH, `rd_addr_e` out REG_ADDR_WIDTH
- `valid_e`, `reg_write_e`, `mem_write_e`, `mem_to_reg_e` out 1

## Operation
- The registered fields are all `*_d` inputs.
- Each rising edge, priority is rst > flush > stall > load.
- **rst:** every register is cleared to 0. This gives `valid_e`=0, all write enables 0, `ALUCtrl`=4'b0000, and all addresses and data 0.
- **flush:** a bubble is loaded. The bubble has valid=0, reg_write=0, mem_write=0, mem_to_reg=0, alu_ctrl=0000 and rd=0; the data fields are zeroed.
- **stall (no flush):** all registers keep their value.
- **Otherwise:** all `*_d` inputs are captured.
- **Forwarding:** combinational, computed from the registered rs1/rs2 addresses and the live `exm_*`/`mwb_*` inputs. This is done for each source independently.
  - EX/MEM is selected if `exm_reg_write` && `exm_rd`!=0 && `exm_rd`==rs.
  - Else MEM/WB is selected under the same conditions with the `mwb_*` inputs.
  - Else the registered register data is used.
  - EX/MEM beats MEM/WB when both match.
  - Register 0 is never forwarded.
  - Forwarding is suppressed when `valid_e`=0.
- **Operand 1:** `ALUop1` = `alu_src_a` ? `pc_e` : fwd_rs1.
- **Operand 2:** `ALUop2` = `alu_src_b` ? imm : fwd_rs2.
- **Store data:** `store_data_e` = fwd_rs2 always, regardless of `alu_src_b`.
- **No width changes:** no arithmetic is performed and no sign extension is done. The immediate arrives already extended.
- **Hazard detection:** load-use stall generation is external. This block only obeys `stall`/`flush`.

## Timing
- Fields enter one cycle after they are presented on `*_d` (a one-stage register).
- The ALU outputs are combinational from the registers plus the forwarding inputs, with zero added latency.
- A change on `exm_result` in the same cycle propagates to `ALUop1`/`ALUop2` in that same cycle.
- During a stall, the forwarding muxes keep evaluating. A held instruction therefore picks up newly written downstream results.
- Mid-operation reset clears the stage on that edge. The outputs show the bubble (above) in the following cycle.

## Configuration
- **`IDEX_FORWARD_EN` defined:** forwarding is implemented as described above.
- **`IDEX_FORWARD_EN` undefined:** fwd_rs1/fwd_rs2 are the registered `rs*_data` values. The `exm_*`/`mwb_*` inputs are ignored (ports remain), and the software/hazard unit must insert stalls instead.

## Structure
- **Shared package `riscv_pkg`:**
  - width constants: DATA_WIDTH, ALUCTRL_WIDTH, REG_ADDR_WIDTH
  - ALU opcode constants: ALU_ADD=4'b0000, ALU_SUB=4'b1000, etc.
  - enum `fwd_sel_t` {FWD_REG, FWD_EXM, FWD_MWB}
  - packed struct `id_ex_t` for the registered bundle
- **Sub-module `forward_unit`:** pure combinational. It takes rs, `valid`, `exm_*` and `mwb_*`, and returns `fwd_sel_t`. It is instantiated twice, once for rs1 and once for rs2, and is compiled only under `IDEX_FORWARD_EN`.

## Test plan
- **Reset:** assert `rst` with all inputs at random values → after the edge, `valid_e`=0, `reg_write_e`=0, `ALUCtrl`=0, `ALUop1`=`ALUop2`=0.
- **Plain load:** rs1_data=5, rs2_data=7, alu_ctrl=1000, alu_src_b=0 → next cycle `ALUCtrl`=1000, `ALUop1`=5, `ALUop2`=7.
- **Forward priority:** rs1=3 registered; exm_rd=3/exm_result=0xAA and mwb_rd=3/mwb_result=0xBB, both write-enabled → `ALUop1`=0xAA. Drop `exm_reg_write` → `ALUop1`=0xBB.
- **x0 and disabled writers:** rs1=0 with exm_rd=0, exm_result=0xFF → `ALUop1`=the rs1_data register value. rs2=4 with mwb_rd=4 but `mwb_reg_write`=0 → no forward.
- **Stall then flush:** hold `stall` for 3 cycles with changing `*_d` → outputs constant. Then assert `stall`+`flush` together → bubble (flush wins).
- **Immediate and PC selects:** alu_src_a=1, pc=0x100, alu_src_b=1, imm=0xFFFFFFFC, rs2 forwarded 0x55 → `ALUop1`=0x100, `ALUop2`=0xFFFFFFFC, `store_data_e`=0x55.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, ALU opcodes, forwarding-select enum and the ID/EX register bundle.
package riscv_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned ALUCTRL_WIDTH  = 4;
   localparam int unsigned REG_ADDR_WIDTH = 5;

   // ALU opcode is {func7[5], func3}
   typedef enum logic [ALUCTRL_WIDTH-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_t;

   typedef enum logic [1:0] {FWD_REG, FWD_EXM, FWD_MWB} fwd_sel_t;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     rs1_data;
      logic [DATA_WIDTH-1:0]     rs2_data;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] rs1_addr;
      logic [REG_ADDR_WIDTH-1:0] rs2_addr;
      logic [REG_ADDR_WIDTH-1:0] rd_addr;
      logic [ALUCTRL_WIDTH-1:0]  alu_ctrl;
      logic                      alu_src_a;
      logic                      alu_src_b;
      logic                      reg_write;
      logic                      mem_write;
      logic                      mem_to_reg;
   } id_ex_t;

endpackage

// File: rtl/forward_unit.sv
// Per-source forwarding select: EX/MEM beats MEM/WB, x0 and invalid slots never forward.
// Only present when IDEX_FORWARD_EN is defined.
`ifdef IDEX_FORWARD_EN
module forward_unit
   import riscv_pkg::*;
(
   input  logic                      valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs_i,
   input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
   input  logic                      exm_reg_write_i,
   input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_i,
   input  logic                      mwb_reg_write_i,
   output fwd_sel_t                  sel_o
);

   always_comb begin
      sel_o = FWD_REG;
      if (valid_i && (rs_i != '0)) begin
         if (exm_reg_write_i && (exm_rd_i == rs_i)) begin
            sel_o = FWD_EXM;
         end else if (mwb_reg_write_i && (mwb_rd_i == rs_i)) begin
            sel_o = FWD_MWB;
         end
      end
   end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and ALU operand selection.
// Define IDEX_FORWARD_EN to forward EX/MEM and MEM/WB results into the operands.
module id_ex_stage
   import riscv_pkg::*;
#(
   // Overrides must match the riscv_pkg widths used by the register bundle
   parameter int unsigned DATA_WIDTH     = riscv_pkg::DATA_WIDTH,
   parameter int unsigned ALUCTRL_WIDTH  = riscv_pkg::ALUCTRL_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      valid_d,
   input  logic [DATA_WIDTH-1:0]     pc_d,
   input  logic [DATA_WIDTH-1:0]     rs1_data_d,
   input  logic [DATA_WIDTH-1:0]     rs2_data_d,
   input  logic [DATA_WIDTH-1:0]     imm_d,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_d,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_d,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_d,
   input  logic [ALUCTRL_WIDTH-1:0]  alu_ctrl_d,
   input  logic                      alu_src_a_d,
   input  logic                      alu_src_b_d,
   input  logic                      reg_write_d,
   input  logic                      mem_write_d,
   input  logic                      mem_to_reg_d,
   input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
   input  logic [REG_ADDR_WIDTH-1:0] mwb_rd,
   input  logic                      exm_reg_write,
   input  logic                      mwb_reg_write,
   input  logic [DATA_WIDTH-1:0]     exm_result,
   input  logic [DATA_WIDTH-1:0]     mwb_result,
   output logic [ALUCTRL_WIDTH-1:0]  ALUCtrl,
   output logic [DATA_WIDTH-1:0]     ALUop1,
   output logic [DATA_WIDTH-1:0]     ALUop2,
   output logic [DATA_WIDTH-1:0]     store_data_e,
   output logic [DATA_WIDTH-1:0]     pc_e,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_e,
   output logic                      valid_e,
   output logic                      reg_write_e,
   output logic                      mem_write_e,
   output logic                      mem_to_reg_e
);

   id_ex_t id_ex_q, id_ex_d;
   logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

   // Bubble is all-zero: invalid, no writes, ALU_ADD, rd = x0
   always_comb begin
      id_ex_d = id_ex_q;
      if (flush) begin
         id_ex_d          = '0;
         id_ex_d.alu_ctrl = ALU_ADD;
      end else if (!stall) begin
         id_ex_d.valid      = valid_d;
         id_ex_d.pc         = pc_d;
         id_ex_d.rs1_data   = rs1_data_d;
         id_ex_d.rs2_data   = rs2_data_d;
         id_ex_d.imm        = imm_d;
         id_ex_d.rs1_addr   = rs1_addr_d;
         id_ex_d.rs2_addr   = rs2_addr_d;
         id_ex_d.rd_addr    = rd_addr_d;
         id_ex_d.alu_ctrl   = alu_ctrl_d;
         id_ex_d.alu_src_a  = alu_src_a_d;
         id_ex_d.alu_src_b  = alu_src_b_d;
         id_ex_d.reg_write  = reg_write_d;
         id_ex_d.mem_write  = mem_write_d;
         id_ex_d.mem_to_reg = mem_to_reg_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

`ifdef IDEX_FORWARD_EN
   fwd_sel_t sel_rs1, sel_rs2;

   forward_unit u_fwd_rs1 (
      .valid_i         (id_ex_q.valid),
      .rs_i            (id_ex_q.rs1_addr),
      .exm_rd_i        (exm_rd),
      .exm_reg_write_i (exm_reg_write),
      .mwb_rd_i        (mwb_rd),
      .mwb_reg_write_i (mwb_reg_write),
      .sel_o           (sel_rs1)
   );

   forward_unit u_fwd_rs2 (
      .valid_i         (id_ex_q.valid),
      .rs_i            (id_ex_q.rs2_addr),
      .exm_rd_i        (exm_rd),
      .exm_reg_write_i (exm_reg_write),
      .mwb_rd_i        (mwb_rd),
      .mwb_reg_write_i (mwb_reg_write),
      .sel_o           (sel_rs2)
   );

   always_comb begin
      case (sel_rs1)
         FWD_EXM: fwd_rs1 = exm_result;
         FWD_MWB: fwd_rs1 = mwb_result;
         default: fwd_rs1 = id_ex_q.rs1_data;
      endcase
      case (sel_rs2)
         FWD_EXM: fwd_rs2 = exm_result;
         FWD_MWB: fwd_rs2 = mwb_result;
         default: fwd_rs2 = id_ex_q.rs2_data;
      endcase
   end
`else
   // Hazards are resolved by stalling upstream; downstream ports are inert
   logic unused_fwd;
   assign unused_fwd = ^{exm_rd, mwb_rd, exm_reg_write, mwb_reg_write, exm_result,
                         mwb_result, id_ex_q.rs1_addr, id_ex_q.rs2_addr};

   assign fwd_rs1 = id_ex_q.rs1_data;
   assign fwd_rs2 = id_ex_q.rs2_data;
`endif

   assign ALUCtrl      = id_ex_q.alu_ctrl;
   assign ALUop1       = id_ex_q.alu_src_a ? id_ex_q.pc : fwd_rs1;
   assign ALUop2       = id_ex_q.alu_src_b ? id_ex_q.imm : fwd_rs2;
   assign store_data_e = fwd_rs2;
   assign pc_e         = id_ex_q.pc;
   assign rd_addr_e    = id_ex_q.rd_addr;
   assign valid_e      = id_ex_q.valid;
   assign reg_write_e  = id_ex_q.reg_write;
   assign mem_write_e  = id_ex_q.mem_write;
   assign mem_to_reg_e = id_ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_d;
   logic [31:0] pc_d, rs1_data_d, rs2_data_d, imm_d;
   logic [4:0]  rs1_addr_d, rs2_addr_d, rd_addr_d;
   logic [3:0]  alu_ctrl_d;
   logic        alu_src_a_d, alu_src_b_d, reg_write_d, mem_write_d, mem_to_reg_d;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_reg_write, mwb_reg_write;
   logic [31:0] exm_result, mwb_result;
   logic [3:0]  ALUCtrl;
   logic [31:0] ALUop1, ALUop2, store_data_e, pc_e;
   logic [4:0]  rd_addr_e;
   logic        valid_e, reg_write_e, mem_write_e, mem_to_reg_e;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: what the stage currently holds
   logic        m_valid, m_sa, m_sb, m_rw, m_mw, m_mr;
   logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
   logic [4:0]  m_rs1a, m_rs2a, m_rd;
   logic [3:0]  m_ctrl;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .valid_d       (valid_d),
      .pc_d          (pc_d),
      .rs1_data_d    (rs1_data_d),
      .rs2_data_d    (rs2_data_d),
      .imm_d         (imm_d),
      .rs1_addr_d    (rs1_addr_d),
      .rs2_addr_d    (rs2_addr_d),
      .rd_addr_d     (rd_addr_d),
      .alu_ctrl_d    (alu_ctrl_d),
      .alu_src_a_d   (alu_src_a_d),
      .alu_src_b_d   (alu_src_b_d),
      .reg_write_d   (reg_write_d),
      .mem_write_d   (mem_write_d),
      .mem_to_reg_d  (mem_to_reg_d),
      .exm_rd        (exm_rd),
      .mwb_rd        (mwb_rd),
      .exm_reg_write (exm_reg_write),
      .mwb_reg_write (mwb_reg_write),
      .exm_result    (exm_result),
      .mwb_result    (mwb_result),
      .ALUCtrl       (ALUCtrl),
      .ALUop1        (ALUop1),
      .ALUop2        (ALUop2),
      .store_data_e  (store_data_e),
      .pc_e          (pc_e),
      .rd_addr_e     (rd_addr_e),
      .valid_e       (valid_e),
      .reg_write_e   (reg_write_e),
      .mem_write_e   (mem_write_e),
      .mem_to_reg_e  (mem_to_reg_e)
   );

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
`ifdef IDEX_FORWARD_EN
      if (m_valid && rs != 5'd0) begin
         if (exm_reg_write && exm_rd == rs) return exm_result;
         if (mwb_reg_write && mwb_rd == rs) return mwb_result;
      end
`endif
      return regval;
   endfunction

   function automatic logic [31:0] exp_op1();
      return m_sa ? m_pc : fwd(m_rs1a, m_rs1d);
   endfunction

   function automatic logic [31:0] exp_op2();
      return m_sb ? m_imm : fwd(m_rs2a, m_rs2d);
   endfunction

   task automatic model_clear();
      {m_valid, m_sa, m_sb, m_rw, m_mw, m_mr} = '0;
      {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
      {m_rs1a, m_rs2a, m_rd, m_ctrl} = '0;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge
   task automatic step();
      @(posedge clk);
      if (rst || flush) begin
         model_clear();
      end else if (!stall) begin
         m_valid = valid_d; m_pc = pc_d; m_rs1d = rs1_data_d; m_rs2d = rs2_data_d;
         m_imm = imm_d; m_rs1a = rs1_addr_d; m_rs2a = rs2_addr_d; m_rd = rd_addr_d;
         m_ctrl = alu_ctrl_d; m_sa = alu_src_a_d; m_sb = alu_src_b_d;
         m_rw = reg_write_d; m_mw = mem_write_d; m_mr = mem_to_reg_d;
      end
      #1;
   endtask

   task automatic rand_inputs();
      valid_d = 1'($urandom); pc_d = $urandom; rs1_data_d = $urandom; rs2_data_d = $urandom;
      imm_d = $urandom; rs1_addr_d = 5'($urandom); rs2_addr_d = 5'($urandom);
      rd_addr_d = 5'($urandom); alu_ctrl_d = 4'($urandom); alu_src_a_d = 1'($urandom);
      alu_src_b_d = 1'($urandom); reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
      mem_to_reg_d = 1'($urandom);
      exm_rd = 5'($urandom); mwb_rd = 5'($urandom); exm_reg_write = 1'($urandom);
      mwb_reg_write = 1'($urandom); exm_result = $urandom; mwb_result = $urandom;
   endtask

   task automatic quiet_writers();
      exm_reg_write = 1'b0; mwb_reg_write = 1'b0;
   endtask

   task automatic test_reset();
      rand_inputs();
      rst = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
      step();
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      n_cmp++;
      if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got v=%b rw=%b mw=%b want 0 0 0",
                  valid_e, reg_write_e, mem_write_e);
      end
      n_cmp++;
      if (ALUCtrl !== 4'b0000) begin
         n_fail++; $display("FAIL reset_aluctrl: got %h want 0", ALUCtrl);
      end
      n_cmp++;
      if (ALUop1 !== 32'd0 || ALUop2 !== 32'd0) begin
         n_fail++; $display("FAIL reset_ops: got %h %h want 0 0", ALUop1, ALUop2);
      end
   endtask

   task automatic test_plain_load();
      rand_inputs(); quiet_writers();
      valid_d = 1'b1; rs1_data_d = 32'd5; rs2_data_d = 32'd7; alu_ctrl_d = 4'b1000;
      alu_src_a_d = 1'b0; alu_src_b_d = 1'b0;
      step();
      n_cmp++;
      if (ALUCtrl !== 4'b1000 || ALUop1 !== 32'd5 || ALUop2 !== 32'd7) begin
         n_fail++;
         $display("FAIL plain_load: got ctrl=%h op1=%h op2=%h want 8 5 7", ALUCtrl, ALUop1, ALUop2);
      end
   endtask

   task automatic test_forward_priority();
      logic [31:0] want;
      rand_inputs();
      valid_d = 1'b1; rs1_addr_d = 5'd3; rs1_data_d = 32'h1111; alu_src_a_d = 1'b0;
      exm_rd = 5'd3; exm_result = 32'hAA; exm_reg_write = 1'b1;
      mwb_rd = 5'd3; mwb_result = 32'hBB; mwb_reg_write = 1'b1;
      step();
`ifdef IDEX_FORWARD_EN
      want = 32'hAA;
`else
      want = 32'h1111;
`endif
      n_cmp++;
      if (ALUop1 !== want) begin
         n_fail++; $display("FAIL fwd_exm_priority: got %h want %h", ALUop1, want);
      end
      exm_reg_write = 1'b0;
      #1;
`ifdef IDEX_FORWARD_EN
      want = 32'hBB;
`endif
      n_cmp++;
      if (ALUop1 !== want) begin
         n_fail++; $display("FAIL fwd_mwb: got %h want %h", ALUop1, want);
      end
      // Same-cycle change on exm_result must reach the operand combinationally
      exm_reg_write = 1'b1; exm_result = 32'hCC;
      #1;
`ifdef IDEX_FORWARD_EN
      want = 32'hCC;
`endif
      n_cmp++;
      if (ALUop1 !== want) begin
         n_fail++; $display("FAIL fwd_comb: got %h want %h", ALUop1, want);
      end
   endtask

   task automatic test_x0_disabled();
      rand_inputs();
      valid_d = 1'b1; alu_src_a_d = 1'b0; alu_src_b_d = 1'b0;
      rs1_addr_d = 5'd0; rs1_data_d = 32'h1234; rs2_addr_d = 5'd4; rs2_data_d = 32'h4444;
      exm_rd = 5'd0; exm_result = 32'hFF; exm_reg_write = 1'b1;
      mwb_rd = 5'd4; mwb_result = 32'h99; mwb_reg_write = 1'b0;
      step();
      n_cmp++;
      if (ALUop1 !== 32'h1234) begin
         n_fail++; $display("FAIL x0_no_fwd: got %h want %h", ALUop1, 32'h1234);
      end
      n_cmp++;
      if (ALUop2 !== 32'h4444) begin
         n_fail++; $display("FAIL disabled_writer: got %h want %h", ALUop2, 32'h4444);
      end
      // Invalid slot never forwards even on an exact match
      valid_d = 1'b0; rs1_addr_d = 5'd3; rs1_data_d = 32'h3333; exm_rd = 5'd3;
      step();
      n_cmp++;
      if (ALUop1 !== 32'h3333) begin
         n_fail++; $display("FAIL invalid_no_fwd: got %h want %h", ALUop1, 32'h3333);
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] op1_h, op2_h;
      logic [3:0]  ctrl_h;
      rand_inputs(); quiet_writers(); valid_d = 1'b1; reg_write_d = 1'b1; rd_addr_d = 5'd9;
      step();
      op1_h = exp_op1(); op2_h = exp_op2(); ctrl_h = m_ctrl;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); quiet_writers();
         step();
         n_cmp++;
         if (ALUop1 !== op1_h || ALUop2 !== op2_h || ALUCtrl !== ctrl_h
             || valid_e !== 1'b1 || rd_addr_e !== 5'd9) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h %h %h v=%b rd=%0d want %h %h %h v=1 rd=9",
                     i, ALUop1, ALUop2, ALUCtrl, valid_e, rd_addr_e, op1_h, op2_h, ctrl_h);
         end
      end
      flush = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0;
      n_cmp++;
      if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0
          || mem_to_reg_e !== 1'b0 || ALUCtrl !== 4'b0000 || rd_addr_e !== 5'd0) begin
         n_fail++;
         $display("FAIL flush_bubble: got v=%b rw=%b mw=%b mr=%b ctrl=%h rd=%0d want all 0",
                  valid_e, reg_write_e, mem_write_e, mem_to_reg_e, ALUCtrl, rd_addr_e);
      end
      n_cmp++;
      if (ALUop1 !== 32'd0 || ALUop2 !== 32'd0 || pc_e !== 32'd0) begin
         n_fail++;
         $display("FAIL flush_data: got %h %h %h want 0 0 0", ALUop1, ALUop2, pc_e);
      end
   endtask

   task automatic test_imm_pc();
      logic [31:0] want_sd;
      rand_inputs(); quiet_writers();
      valid_d = 1'b1; alu_src_a_d = 1'b1; pc_d = 32'h100; alu_src_b_d = 1'b1;
      imm_d = 32'hFFFF_FFFC; rs2_addr_d = 5'd6; rs2_data_d = 32'h12;
      exm_rd = 5'd6; exm_result = 32'h55; exm_reg_write = 1'b1;
      step();
`ifdef IDEX_FORWARD_EN
      want_sd = 32'h55;
`else
      want_sd = 32'h12;
`endif
      n_cmp++;
      if (ALUop1 !== 32'h100 || ALUop2 !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL imm_pc_ops: got %h %h want 00000100 fffffffc", ALUop1, ALUop2);
      end
      n_cmp++;
      if (store_data_e !== want_sd) begin
         n_fail++; $display("FAIL store_fwd: got %h want %h", store_data_e, want_sd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         rs1_addr_d = 5'($urandom_range(0, 3)); rs2_addr_d = 5'($urandom_range(0, 3));
         rst   = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 4) == 0);
         step();
         rst = 1'b0;
         // Re-drive the downstream buses mid-cycle; operands must follow at once
         exm_rd = 5'($urandom_range(0, 3)); mwb_rd = 5'($urandom_range(0, 3));
         exm_reg_write = 1'($urandom); mwb_reg_write = 1'($urandom);
         exm_result = $urandom; mwb_result = $urandom;
         #1;
         n_cmp++;
         if (ALUop1 !== exp_op1() || ALUop2 !== exp_op2()
             || store_data_e !== fwd(m_rs2a, m_rs2d)) begin
            n_fail++;
            $display("FAIL rand_ops[%0d]: got %h %h %h want %h %h %h", i, ALUop1, ALUop2,
                     store_data_e, exp_op1(), exp_op2(), fwd(m_rs2a, m_rs2d));
         end
         n_cmp++;
         if (ALUCtrl !== m_ctrl || pc_e !== m_pc || rd_addr_e !== m_rd || valid_e !== m_valid
             || reg_write_e !== m_rw || mem_write_e !== m_mw || mem_to_reg_e !== m_mr) begin
            n_fail++;
            $display("FAIL rand_side[%0d]: got %h %h %0d %b%b%b%b want %h %h %0d %b%b%b%b", i,
                     ALUCtrl, pc_e, rd_addr_e, valid_e, reg_write_e, mem_write_e, mem_to_reg_e,
                     m_ctrl, m_pc, m_rd, m_valid, m_rw, m_mw, m_mr);
         end
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      model_clear();
      rand_inputs();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_plain_load();
      test_forward_priority();
      test_x0_disabled();
      test_stall_flush();
      test_imm_pc();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
